// File: rtl/layer_serializer_pkg.sv
// nn_pkg: types and constants shared by the layer serializer slice.
//   DATA_W  : default neuron output word width
//   clog2   : ceiling log2, for constant parameter expressions
//   idx_w   : index width for an NN-word vector (at least 1 bit)
//   state_t : serializer FSM state
package nn_pkg;

  localparam int DATA_W = 16;

  typedef enum logic {IDLE, SHIFT} state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/layer_serializer_if.sv
// layer_serializer_if: bundle between an upstream layer's parallel outputs
// and the serial stream feeding the next layer.
//   layer_valid / layer_data : parallel vector from layer N
//   x_valid / x_out / busy   : serial stream toward layer N+1
//   overflow / partial_err   : sticky error flags
//   max_idx / max_valid      : argmax result (LAYER_SERIALIZER_ARGMAX_EN only)
// Modports: master = upstream/consumer side (testbench), slave = serializer.
interface layer_serializer_if #(
  parameter int NN = 10,
  parameter int DW = 16
);
  import nn_pkg::*;

  localparam int IW = idx_w(NN);

  logic [NN-1:0]    layer_valid;
  logic [NN*DW-1:0] layer_data;
  logic             x_valid;
  logic [DW-1:0]    x_out;
  logic             busy;
  logic             overflow;
  logic             partial_err;
`ifdef LAYER_SERIALIZER_ARGMAX_EN
  logic [IW-1:0]    max_idx;
  logic             max_valid;

  modport master (output layer_valid, layer_data,
                  input  x_valid, x_out, busy, overflow, partial_err,
                  input  max_idx, max_valid);
  modport slave  (input  layer_valid, layer_data,
                  output x_valid, x_out, busy, overflow, partial_err,
                  output max_idx, max_valid);
`else
  modport master (output layer_valid, layer_data,
                  input  x_valid, x_out, busy, overflow, partial_err);
  modport slave  (input  layer_valid, layer_data,
                  output x_valid, x_out, busy, overflow, partial_err);
`endif

endinterface

// File: rtl/layer_serializer_argmax_acc.sv
// layer_argmax_acc: running signed maximum over the serial word stream.
//   clk, rst   : clock, async active-high reset
//   in_valid   : a stream word is on in_data this cycle
//   in_first   : this word is word 0 of a vector (restarts the compare)
//   in_last    : this word is word NN-1 of a vector
//   in_data    : signed stream word
//   in_idx     : index of in_data within its vector
//   max_idx    : index of the largest word, lowest index on ties
//   max_valid  : one-cycle pulse the cycle after the last word
module layer_argmax_acc
  import nn_pkg::*;
#(
  parameter int NN = 10,
  parameter int DW = DATA_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic                   in_first,
  input  logic                   in_last,
  input  logic signed [DW-1:0]   in_data,
  input  logic [idx_w(NN)-1:0]   in_idx,
  output logic [idx_w(NN)-1:0]   max_idx,
  output logic                   max_valid
);

  localparam int IW = idx_w(NN);

  logic signed [DW-1:0] best_q;
  logic [IW-1:0]        bidx_q;
  logic                 take;
  logic signed [DW-1:0] cand_val;
  logic [IW-1:0]        cand_idx;

  // Strict greater-than keeps the earlier index on ties.
  always_comb begin
    take     = in_first || (in_data > best_q);
    cand_val = take ? in_data : best_q;
    cand_idx = take ? in_idx  : bidx_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_q    <= '0;
      bidx_q    <= '0;
      max_idx   <= '0;
      max_valid <= 1'b0;
    end else begin
      max_valid <= in_valid && in_last;
      if (in_valid) begin
        best_q <= cand_val;
        bidx_q <= cand_idx;
        if (in_last) max_idx <= cand_idx;
      end
    end
  end

endmodule

// File: rtl/layer_serializer.sv
// layer_serializer: captures a full NN-word neuron vector when every
// per-neuron valid is high and streams it out one word per clock.
// Optional argmax unit enabled by defining LAYER_SERIALIZER_ARGMAX_EN.
//   clk, rst : clock, async active-high reset
//   bus      : layer_serializer_if.slave (parallel in, serial out, flags)
//
// state | meaning
// IDLE  | no stream; x_valid low, x_out holds last word
// SHIFT | streaming; x_out holds word cnt of the captured vector
module layer_serializer
  import nn_pkg::*;
#(
  parameter int NN        = 10,
  parameter int dataWidth = DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  layer_serializer_if.slave bus
);

  localparam int            IW       = idx_w(NN);
  localparam logic [IW-1:0] LAST_IDX = IW'(NN - 1);

  state_t                     state_q, state_d;
  logic [IW-1:0]              cnt_q, cnt_d;
  logic [NN*dataWidth-1:0]    sr_q, sr_d;
  logic                       x_valid_q, x_valid_d;
  logic [dataWidth-1:0]       x_out_q, x_out_d;
  logic                       overflow_q, overflow_d;
  logic                       partial_q, partial_d;
  logic                       capture, partial_hit, at_last, load;

  assign capture     = &bus.layer_valid;
  assign partial_hit = (|bus.layer_valid) && !capture;
  assign at_last     = (state_q == SHIFT) && (cnt_q == LAST_IDX);
  // A capture is accepted when idle or on the edge that retires the last word.
  assign load        = capture && ((state_q == IDLE) || at_last);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    x_valid_d  = 1'b0;
    x_out_d    = x_out_q;
    overflow_d = overflow_q;
    partial_d  = partial_q | partial_hit;

    if (load) begin
      // Word 0 goes straight to x_out; the shift register keeps words 1..NN-1.
      state_d   = SHIFT;
      cnt_d     = '0;
      x_valid_d = 1'b1;
      x_out_d   = bus.layer_data[dataWidth-1:0];
      sr_d      = bus.layer_data >> dataWidth;
    end else if ((state_q == SHIFT) && !at_last) begin
      cnt_d     = cnt_q + 1'b1;
      x_valid_d = 1'b1;
      x_out_d   = sr_q[dataWidth-1:0];
      sr_d      = sr_q >> dataWidth;
      if (capture) overflow_d = 1'b1;
    end else begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sr_q       <= '0;
      x_valid_q  <= 1'b0;
      x_out_q    <= '0;
      overflow_q <= 1'b0;
      partial_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      x_valid_q  <= x_valid_d;
      x_out_q    <= x_out_d;
      overflow_q <= overflow_d;
      partial_q  <= partial_d;
    end
  end

  assign bus.x_valid     = x_valid_q;
  assign bus.x_out       = x_out_q;
  assign bus.busy        = x_valid_q;
  assign bus.overflow    = overflow_q;
  assign bus.partial_err = partial_q;

`ifdef LAYER_SERIALIZER_ARGMAX_EN
  // cnt_q is the index of the word currently on x_out.
  layer_argmax_acc #(
    .NN (NN),
    .DW (dataWidth)
  ) u_argmax (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (x_valid_q),
    .in_first  (cnt_q == '0),
    .in_last   (cnt_q == LAST_IDX),
    .in_data   (x_out_q),
    .in_idx    (cnt_q),
    .max_idx   (bus.max_idx),
    .max_valid (bus.max_valid)
  );
`endif

endmodule

// File: tb/tb_layer_serializer.sv
module tb_layer_serializer;
  import nn_pkg::*;

  localparam int NN = 10;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  layer_serializer_if #(.NN(NN), .DW(DW)) bus ();

  layer_serializer #(.NN(NN), .dataWidth(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic          r;
    logic [NN-1:0] lv;
    int            pat;
    logic          ev;
    logic [DW-1:0] ex;
    logic          eo;
    logic          ep;
  } vec_t;

  vec_t tbl[$];
  int passed = 0;
  int total  = 0;

  logic [DW-1:0] am_a [NN];
  logic [DW-1:0] am_b [NN];

  function automatic logic [NN*DW-1:0] pattern(input int p);
    logic [NN*DW-1:0] d;
    d = '0;
    for (int i = 0; i < NN; i++) begin
      case (p)
        0:       d[i*DW +: DW] = 16'(i * 17);
        1:       d[i*DW +: DW] = 16'(32'h1000 + i);
        2:       d[i*DW +: DW] = am_a[i];
        default: d[i*DW +: DW] = am_b[i];
      endcase
    end
    return d;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push(input logic r, input logic [NN-1:0] lv, input int pat,
                      input logic ev, input logic [DW-1:0] ex,
                      input logic eo, input logic ep);
    vec_t v;
    v.r = r; v.lv = lv; v.pat = pat; v.ev = ev; v.ex = ex; v.eo = eo; v.ep = ep;
    tbl.push_back(v);
  endtask

  task automatic check_outs(input string tag, input logic ev, input logic [DW-1:0] ex,
                            input logic eo, input logic ep);
    check({tag, " x_valid"},     32'(bus.x_valid),     32'(ev));
    check({tag, " x_out"},       32'(bus.x_out),       32'(ex));
    check({tag, " busy"},        32'(bus.busy),        32'(ev));
    check({tag, " overflow"},    32'(bus.overflow),    32'(eo));
    check({tag, " partial_err"}, 32'(bus.partial_err), 32'(ep));
  endtask

  // Inputs drive just after an edge, get sampled on the next edge, and
  // outputs are checked 1 time unit after that edge.
  task automatic edge_drive(input logic [NN-1:0] lv, input int pat);
    bus.layer_valid = lv;
    bus.layer_data  = pattern(pat);
    @(posedge clk);
    #1;
    bus.layer_valid = '0;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    bus.layer_valid = '0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    am_a = '{16'd5, 16'hFFFD, 16'h7FFF, 16'd2, 16'h7FFF, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    am_b = '{16'hFFF8, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
             16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    bus.layer_valid = '0;
    bus.layer_data  = '0;
    rst = 1'b1;
    #1;
    check_outs("reset", 1'b0, 16'h0000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic stream.
    push(0, 10'h3FF, 0, 1, 16'h0000, 0, 0);
    for (int i = 1; i < NN; i++) push(0, '0, 0, 1, 16'(i * 17), 0, 0);
    push(0, '0, 0, 0, 16'h0099, 0, 0);
    push(0, '0, 0, 0, 16'h0099, 0, 0);
    // Back-to-back: B captured on the edge that retires A's word 9.
    push(1, '0, 0, 0, 16'h0000, 0, 0);
    push(0, 10'h3FF, 0, 1, 16'h0000, 0, 0);
    for (int i = 1; i < NN; i++) push(0, '0, 0, 1, 16'(i * 17), 0, 0);
    push(0, 10'h3FF, 1, 1, 16'h1000, 0, 0);
    for (int i = 1; i < NN; i++) push(0, '0, 1, 1, 16'(32'h1000 + i), 0, 0);
    push(0, '0, 0, 0, 16'h1009, 0, 0);
    // Overflow: capture mid-stream is dropped.
    push(1, '0, 0, 0, 16'h0000, 0, 0);
    push(0, 10'h3FF, 0, 1, 16'h0000, 0, 0);
    for (int i = 1; i < 4; i++) push(0, '0, 0, 1, 16'(i * 17), 0, 0);
    push(0, 10'h3FF, 1, 1, 16'h0044, 1, 0);
    for (int i = 5; i < NN; i++) push(0, '0, 0, 1, 16'(i * 17), 1, 0);
    push(0, '0, 0, 0, 16'h0099, 1, 0);
    push(0, '0, 0, 0, 16'h0099, 1, 0);
    // Partial valid.
    push(1, '0, 0, 0, 16'h0000, 0, 0);
    push(0, 10'h00F, 0, 0, 16'h0000, 0, 1);
    push(0, '0, 0, 0, 16'h0000, 0, 1);
    push(0, 10'h1FF, 0, 0, 16'h0000, 0, 1);

    for (int n = 0; n < tbl.size(); n++) begin
      if (tbl[n].r) begin
        reset_pulse();
        check_outs($sformatf("vec%0d", n), tbl[n].ev, tbl[n].ex, tbl[n].eo, tbl[n].ep);
        rst = 1'b0;
      end else begin
        edge_drive(tbl[n].lv, tbl[n].pat);
        check_outs($sformatf("vec%0d", n), tbl[n].ev, tbl[n].ex, tbl[n].eo, tbl[n].ep);
      end
    end

    // Reset mid-stream clears outputs without a clock edge.
    reset_pulse();
    rst = 1'b0;
    edge_drive(10'h3FF, 0);
    for (int i = 1; i < 5; i++) edge_drive('0, 0);
    check("mid x_out before rst", 32'(bus.x_out), 32'h0044);
    #2;
    rst = 1'b1;
    #1;
    check("async x_valid", 32'(bus.x_valid), 32'h0);
    check("async x_out",   32'(bus.x_out),   32'h0);
    check("async busy",    32'(bus.busy),    32'h0);
    @(negedge clk);
    rst = 1'b0;
    edge_drive('0, 0);
    check("post-rst idle", 32'(bus.x_valid), 32'h0);
    edge_drive(10'h3FF, 1);
    check_outs("restart w0", 1'b1, 16'h1000, 1'b0, 1'b0);
    for (int i = 1; i < NN; i++) begin
      edge_drive('0, 0);
      check_outs($sformatf("restart w%0d", i), 1'b1, 16'(32'h1000 + i), 1'b0, 1'b0);
    end
    edge_drive('0, 0);
    check_outs("restart end", 1'b0, 16'h1009, 1'b0, 1'b0);

`ifdef LAYER_SERIALIZER_ARGMAX_EN
    reset_pulse();
    check("am reset idx",   32'(bus.max_idx),   32'h0);
    check("am reset valid", 32'(bus.max_valid), 32'h0);
    rst = 1'b0;
    edge_drive(10'h3FF, 2);
    check("am a w0 mv", 32'(bus.max_valid), 32'h0);
    for (int i = 1; i < NN; i++) begin
      edge_drive('0, 0);
      check($sformatf("am a w%0d mv", i), 32'(bus.max_valid), 32'h0);
    end
    edge_drive(10'h3FF, 3);
    check("am a pulse", 32'(bus.max_valid), 32'h1);
    check("am a idx",   32'(bus.max_idx),   32'h2);
    check("am b w0",    32'(bus.x_out),     32'hFFF8);
    for (int i = 1; i < NN; i++) begin
      edge_drive('0, 0);
      check($sformatf("am b w%0d mv", i), 32'(bus.max_valid), 32'h0);
    end
    edge_drive('0, 0);
    check("am b pulse", 32'(bus.max_valid), 32'h1);
    check("am b idx",   32'(bus.max_idx),   32'h1);
    edge_drive('0, 0);
    check("am b pulse end", 32'(bus.max_valid), 32'h0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
